// File: rtl/pc_redirect_unit.sv
// IF-stage program counter with branch redirect, busy-memory redirect holding,
// pipeline flush generation, misaligned-target flag and taken-redirect counter.
module pc_redirect_unit #(
  parameter logic [31:0]  RESET_PC = 32'h0000_0000,
  localparam int unsigned XLEN     = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  input  logic            imem_busy,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            imem_req,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_fault,
  output logic [XLEN-1:0] redirect_count
);

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_REDIR_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_pend;
  logic [XLEN-1:0] w_pend_nxt;
  logic [XLEN-1:0] r_cnt;
  logic [XLEN-1:0] w_target;
  logic            w_redirect;
  logic            w_misalign;
  logic            r_misalign;
  logic            r_imem_req;

  assign w_target   = {branch_target[XLEN-1:2], 2'b00};
  assign w_misalign = branch_taken & (branch_target[1:0] != 2'b00);

  // State, PC, pending target and monitor registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
      r_imem_req <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend     <= w_pend_nxt;
      r_misalign <= w_misalign;
      r_imem_req <= 1'b1;
      if (w_redirect) begin
        r_cnt <= r_cnt + XLEN'(1);
      end
    end
  end

  // Next-PC selection; a taken branch always beats stall since it is older
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_redirect  = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (branch_taken && !imem_busy) begin
          w_pc_nxt   = w_target;
          w_redirect = 1'b1;
        end else if (branch_taken) begin
          w_pend_nxt  = w_target;
          w_state_nxt = ST_REDIR_WAIT;
        end else if (!stall && !imem_busy) begin
          w_pc_nxt = r_pc + XLEN'(4);
        end
      end
      ST_REDIR_WAIT: begin
        if (imem_busy) begin
          if (branch_taken) begin
            w_pend_nxt = w_target;
          end
        end else begin
          // A branch arriving on the exit cycle is the newest redirect
          w_pc_nxt    = branch_taken ? w_target : r_pend;
          w_redirect  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign pc_out         = r_pc;
  assign pc_plus4       = r_pc + XLEN'(4);
  assign imem_req       = r_imem_req;
  assign misalign_fault = r_misalign;
  assign redirect_count = r_cnt;
  assign flush_idex     = ~RESET & branch_taken;
  assign flush_ifid     = ~RESET & (branch_taken | ((r_state == ST_REDIR_WAIT) & ~imem_busy));

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus random
// stimulus compared against a behavioural fetch-address model.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RESET, branch_taken, stall, imem_busy;
  logic [31:0] branch_target;
  logic [31:0] pc_out, pc_plus4, redirect_count;
  logic        imem_req, flush_ifid, flush_idex, misalign_fault;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: address, optional waiting redirect, counters
  logic [31:0] m_pc, m_pend, m_cnt;
  bit          m_pend_v, m_fault, m_req;
  logic        e_ifid, e_idex;
  logic [31:0] e_plus4;

  pc_redirect_unit #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RESET(RESET), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .imem_busy(imem_busy),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .imem_req(imem_req),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .misalign_fault(misalign_fault), .redirect_count(redirect_count)
  );

  always #5 CLK = ~CLK;

  // Apply inputs just after a falling edge and derive expected combinational outputs
  task automatic drive(input logic bt, input logic [31:0] tgt, input logic st,
                       input logic bz, input logic rs);
    branch_taken = bt; branch_target = tgt; stall = st; imem_busy = bz; RESET = rs;
    #1;
    e_ifid  = !rs && (bt || (m_pend_v && !bz));
    e_idex  = !rs && bt;
    e_plus4 = m_pc + 32'd4;
  endtask

  // Advance the model by one clock and wait for the next falling edge
  task automatic tick();
    logic [31:0] aligned;
    aligned = branch_target & 32'hFFFF_FFFC;
    if (RESET) begin
      m_pc = RST_PC; m_pend_v = 0; m_pend = '0; m_cnt = '0; m_fault = 0; m_req = 0;
    end else begin
      m_fault = branch_taken && (branch_target % 4 != 0);
      m_req   = 1;
      if (m_pend_v) begin
        if (!imem_busy) begin
          m_pc = branch_taken ? aligned : m_pend;
          m_pend_v = 0;
          m_cnt = m_cnt + 1;
        end else if (branch_taken) begin
          m_pend = aligned;
        end
      end else if (branch_taken) begin
        if (!imem_busy) begin
          m_pc = aligned;
          m_cnt = m_cnt + 1;
        end else begin
          m_pend = aligned;
          m_pend_v = 1;
        end
      end else if (!stall && !imem_busy) begin
        m_pc = m_pc + 4;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 32'h0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1, 32'h0000_1234, 0, 0, 1);
    n_vec++;
    if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
      n_err++; $display("FAIL reset_flush got %b%b exp 00", flush_ifid, flush_idex);
    end
    tick();
    n_vec++;
    if (pc_out !== RST_PC) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc_out, RST_PC); end
    n_vec++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_vec++;
    if (redirect_count !== 32'd0 || misalign_fault !== 1'b0) begin
      n_err++; $display("FAIL reset_cnt got %h/%b exp 0/0", redirect_count, misalign_fault);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 32'h0, 0, 0, 0);
      tick();
      n_vec++;
      if (pc_out !== RST_PC + 32'(4 * i) || pc_out !== m_pc) begin
        n_err++; $display("FAIL seq_pc%0d got %h exp %h", i, pc_out, RST_PC + 32'(4 * i));
      end
    end
    n_vec++;
    if (imem_req !== 1'b1 || redirect_count !== 32'd0) begin
      n_err++; $display("FAIL post_reset got req %b cnt %h exp 1/0", imem_req, redirect_count);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] c0;
    drive(1, 32'h0000_0200, 0, 0, 0); tick();
    c0 = redirect_count;
    drive(1, 32'h0000_0080, 0, 0, 0);
    n_vec++;
    if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
      n_err++; $display("FAIL redir_flush got %b%b exp 11", flush_ifid, flush_idex);
    end
    n_vec++;
    if (pc_out !== 32'h200 || pc_plus4 !== 32'h204) begin
      n_err++; $display("FAIL redir_pre got %h/%h exp 200/204", pc_out, pc_plus4);
    end
    tick();
    n_vec++;
    if (pc_out !== 32'h80 || redirect_count !== c0 + 1) begin
      n_err++; $display("FAIL redir_pc got %h cnt %h exp 80 cnt %h", pc_out, redirect_count, c0 + 1);
    end
  endtask

  task automatic test_stall();
    drive(1, 32'h0000_0300, 0, 0, 0); tick();
    drive(1, 32'h0000_0040, 1, 0, 0); tick();
    n_vec++;
    if (pc_out !== 32'h40) begin n_err++; $display("FAIL stall_override got %h exp 40", pc_out); end
    drive(1, 32'h0000_0300, 0, 0, 0); tick();
    idle(1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h0, 1, 0, 0);
      n_vec++;
      if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
        n_err++; $display("FAIL stall_flush got %b%b exp 00", flush_ifid, flush_idex);
      end
      tick();
      n_vec++;
      if (pc_out !== 32'h304) begin n_err++; $display("FAIL stall_hold got %h exp 304", pc_out); end
    end
  endtask

  task automatic test_busy();
    logic [31:0] p0, c0;
    p0 = pc_out; c0 = redirect_count;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 32'h0000_0500, 0, 1, 0);
      tick();
      n_vec++;
      if (pc_out !== p0) begin n_err++; $display("FAIL busy_hold%0d got %h exp %h", i, pc_out, p0); end
    end
    drive(0, 32'h0, 0, 0, 0);
    n_vec++;
    if (flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin
      n_err++; $display("FAIL busy_exit_flush got %b%b exp 10", flush_ifid, flush_idex);
    end
    tick();
    n_vec++;
    if (pc_out !== 32'h500 || redirect_count !== c0 + 1) begin
      n_err++; $display("FAIL busy_redir got %h cnt %h exp 500 cnt %h", pc_out, redirect_count, c0 + 1);
    end
    idle(1);
    n_vec++;
    if (redirect_count !== c0 + 1 || pc_out !== 32'h504) begin
      n_err++; $display("FAIL busy_once got %h cnt %h exp 504 cnt %h", pc_out, redirect_count, c0 + 1);
    end
  endtask

  task automatic test_misalign();
    drive(1, 32'h0000_1002, 0, 0, 0); tick();
    n_vec++;
    if (pc_out !== 32'h1000 || misalign_fault !== 1'b1) begin
      n_err++; $display("FAIL misalign got %h/%b exp 1000/1", pc_out, misalign_fault);
    end
    idle(1);
    n_vec++;
    if (misalign_fault !== 1'b0) begin n_err++; $display("FAIL misalign_pulse got %b exp 0", misalign_fault); end
  endtask

  task automatic test_wrap();
    drive(1, 32'hFFFF_FFFC, 0, 0, 0); tick();
    n_vec++;
    if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4); end
    idle(1);
    n_vec++;
    if (pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp 0", pc_out); end
  endtask

  task automatic test_reset_in_wait();
    drive(1, 32'h0000_0700, 0, 1, 0); tick();
    drive(0, 32'h0, 0, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 0, 0, 0);
      n_vec++;
      if (flush_ifid !== 1'b0) begin n_err++; $display("FAIL rstwait_flush got %b exp 0", flush_ifid); end
      tick();
      n_vec++;
      if (pc_out !== RST_PC + 32'(4 * (i + 1)) || redirect_count !== 32'd0) begin
        n_err++; $display("FAIL rstwait_pc got %h cnt %h exp %h cnt 0", pc_out, redirect_count, RST_PC + 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h0000_2000, 0, 1, 0); tick();
    drive(1, 32'h0000_3000, 0, 1, 0); tick();
    drive(1, 32'h0000_4000, 0, 0, 0); tick();
    n_vec++;
    if (pc_out !== m_pc) begin n_err++; $display("FAIL b2b_exit got %h exp %h", pc_out, m_pc); end
    drive(1, 32'h0000_5000, 0, 0, 0); tick();
    drive(1, 32'h0000_6003, 0, 0, 0); tick();
    n_vec++;
    if (pc_out !== 32'h6000 || redirect_count !== m_cnt) begin
      n_err++; $display("FAIL b2b_chain got %h cnt %h exp 6000 cnt %h", pc_out, redirect_count, m_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(3) == 0, $urandom, $urandom_range(3) == 0,
            $urandom_range(2) == 0, $urandom_range(255) == 0);
      n_vec++;
      if (flush_ifid !== e_ifid || flush_idex !== e_idex) begin
        n_err++; $display("FAIL rnd_flush@%0d got %b%b exp %b%b", i, flush_ifid, flush_idex, e_ifid, e_idex);
      end
      n_vec++;
      if (pc_plus4 !== e_plus4) begin n_err++; $display("FAIL rnd_plus4@%0d got %h exp %h", i, pc_plus4, e_plus4); end
      tick();
      n_vec++;
      if (pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc@%0d got %h exp %h", i, pc_out, m_pc); end
      n_vec++;
      if (redirect_count !== m_cnt) begin n_err++; $display("FAIL rnd_cnt@%0d got %h exp %h", i, redirect_count, m_cnt); end
      n_vec++;
      if (misalign_fault !== m_fault || imem_req !== m_req) begin
        n_err++; $display("FAIL rnd_flags@%0d got %b/%b exp %b/%b", i, misalign_fault, imem_req, m_fault, m_req);
      end
    end
  endtask

  initial begin
    m_pc = RST_PC; m_pend = '0; m_cnt = '0; m_pend_v = 0; m_fault = 0; m_req = 0;
    test_reset();
    test_redirect();
    test_stall();
    test_busy();
    test_misalign();
    test_wrap();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter register and redirect controller for the RV32IM pipeline's IF stage. It consumes the taken/not-taken decision and target address produced by the EX-stage branch comparator, and drives the next fetch address to instruction memory. It generates the IF/ID and ID/EX flush requests and holds a pending redirect when instruction memory is busy. It also counts taken redirects for performance monitoring.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- branch_taken  input  1  EX-stage branch decision: conditional taken or JAL/JALR.
- branch_target  input  32  EX-stage computed target address.
- stall  input  1  hazard-unit load-use stall; hold PC.
- imem_busy  input  1  instruction memory has not completed the current fetch.
- pc_out  output  32  current fetch address, registered.
- pc_plus4  output  32  pc_out + 4, combinational, modulo 2^32.
- imem_req  output  1  fetch request for pc_out.
- flush_ifid  output  1  squash the IF/ID register on this edge.
- flush_idex  output  1  squash the ID/EX register on this edge.
- misalign_fault  output  1  one-cycle pulse: taken target had bits [1:0] != 0.
- redirect_count  output  32  number of redirects applied; wraps.

## Operation
- States:
  - RUN: normal fetch.
  - REDIR_WAIT: a redirect is latched and waiting for imem_busy to drop.
- Next-PC priority in RUN, evaluated each edge:
  - RESET: pc_out = RESET_PC.
  - branch_taken & ~imem_busy: pc_out = {branch_target[31:2], 2'b00}.
  - branch_taken & imem_busy: latch the target into pending_target, go to REDIR_WAIT, hold pc_out.
  - stall | imem_busy: hold pc_out.
  - otherwise: pc_out = pc_out + 4.
- branch_taken overrides stall. The branch is older than the stalled instruction.
- REDIR_WAIT:
  - While imem_busy: hold pc_out. A new branch_taken overwrites pending_target (latest wins).
  - First cycle with imem_busy = 0: pc_out = pending_target, return to RUN. Assert flush_ifid this cycle to discard the stale fetch that just completed.
- Flushes are combinational:
  - flush_ifid = branch_taken | (state == REDIR_WAIT & ~imem_busy).
  - flush_idex = branch_taken.
  - Both are forced to 0 while RESET.
- misalign_fault: registered; 1 for exactly one cycle after any edge where branch_taken is sampled with branch_target[1:0] != 0. The redirect still occurs, with the low bits cleared.
- redirect_count: increments by 1 on each edge where pc_out is loaded from a branch target, from either the direct path or the REDIR_WAIT exit. Wraps 0xFFFF_FFFF -> 0.
- imem_req: 0 during and in the cycle of RESET, otherwise 1.

## Timing
- Reset values: pc_out = RESET_PC, state = RUN, pending_target = 0, misalign_fault = 0, redirect_count = 0, imem_req = 0.
- Redirect latency:
  - Target appears on pc_out 1 cycle after branch_taken is sampled when imem_busy = 0.
  - Otherwise 1 cycle after the first non-busy cycle.
- Sequential increment: pc_out advances by 4 per non-stalled, non-busy cycle. 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- RESET asserted in REDIR_WAIT: pending redirect is discarded and pc_out = RESET_PC next edge.
- pc_plus4 and the flush outputs have zero-cycle latency. All other outputs change only on rising CLK.

## Test plan
- Reset with RESET_PC = 0x100, then 3 free-running cycles -> pc_out sequence 0x100, 0x104, 0x108, 0x10C; imem_req = 1 after reset; redirect_count = 0.
- pc_out = 0x200, branch_taken = 1, target = 0x80, imem_busy = 0:
  - flush_ifid = flush_idex = 1 that cycle.
  - Next cycle pc_out = 0x80, redirect_count = 1.
- pc_out = 0x300, stall = 1 and branch_taken = 1 with target = 0x40 -> pc_out = 0x40 next cycle (branch overrides stall). Stall alone for 2 cycles -> pc_out stays 0x304.
- imem_busy = 1 for 3 cycles, with branch_taken (target 0x500) in the first busy cycle:
  - pc_out holds.
  - On the first non-busy cycle, flush_ifid = 1.
  - Next cycle pc_out = 0x500.
  - redirect_count increments once.
- Target 0x1002 taken -> pc_out = 0x1000; misalign_fault = 1 for exactly one cycle.
- RESET asserted while in REDIR_WAIT with pending 0x700 -> pc_out = RESET_PC; no later jump to 0x700; redirect_count = 0.
